// File: rtl/div_req_frontend.sv
// Request/response wrapper around the iterative divider: screens divide-by-zero,
// sequences operands and the go pulse, and aborts a hung divider after TIMEOUT cycles.
module div_req_frontend #(
    parameter int W       = 4,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [W-1:0]    req_x,
    input  logic [W-1:0]    req_y,
    output logic [W-1:0]    dv_x,
    output logic [W-1:0]    dv_y,
    output logic            dv_go,
    output logic            dv_error,
    output logic            dv_rst,
    input  logic            dv_done,
    input  logic [W-1:0]    dv_q,
    input  logic [W-1:0]    dv_r,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_q,
    output logic [W-1:0]    rsp_r,
    output logic [1:0]      rsp_err,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    // state   | meaning
    // S_IDLE  | waiting for a request; req_ready high
    // S_LOAD  | operands presented to the divider, one settle cycle
    // S_START | dv_go pulse; watchdog timer cleared
    // S_WAIT  | waiting for dv_done or watchdog expiry
    // S_RESP  | response held until the consumer accepts it

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    x_reg, y_reg;
    logic [TW-1:0]   timer;
    logic            drive_dv;
    logic            timeout_hit;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dv_go     = (state == S_START);
    assign rsp_valid = (state == S_RESP);

    // Operands reach the divider only while it owns the transaction.
    assign drive_dv  = (state == S_LOAD) || (state == S_START) || (state == S_WAIT);
    assign dv_x      = drive_dv ? x_reg : '0;
    assign dv_y      = drive_dv ? y_reg : '0;
    assign dv_error  = drive_dv && (y_reg == '0);

    // A done arriving on the final watchdog cycle takes priority over the abort.
    assign timeout_hit = (state == S_WAIT) && (timer == TW'(TIMEOUT - 1)) && !dv_done;
    assign dv_rst      = timeout_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = (req_y == '0) ? S_RESP : S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (dv_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            x_reg    <= '0;
            y_reg    <= '0;
            timer    <= '0;
            rsp_q    <= '0;
            rsp_r    <= '0;
            rsp_err  <= 2'b00;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        x_reg <= req_x;
                        y_reg <= req_y;
                        if (req_y == '0) begin
                            rsp_q   <= '0;
                            rsp_r   <= req_x;
                            rsp_err <= 2'b01;
                        end
                    end
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (dv_done) begin
                        rsp_q   <= dv_q;
                        rsp_r   <= dv_r;
                        rsp_err <= 2'b00;
                    end else if (timeout_hit) begin
                        rsp_q   <= '0;
                        rsp_r   <= '0;
                        rsp_err <= 2'b10;
                    end
                end
                S_RESP: if (rsp_ready) op_count <= op_count + CNTW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_frontend.sv
// Scoreboard bench for div_req_frontend with a behavioural divider stub whose
// latency (or hang) is chosen per transaction.
module tb_div_req_frontend;
    localparam int W       = 4;
    localparam int TIMEOUT = 64;
    localparam int CNTW    = 8;

    logic            clk, rst;
    logic            req_valid, req_ready;
    logic [W-1:0]    req_x, req_y, dv_x, dv_y, dv_q, dv_r, rsp_q, rsp_r;
    logic            dv_go, dv_error, dv_rst, dv_done;
    logic            rsp_valid, rsp_ready, busy;
    logic [1:0]      rsp_err;
    logic [CNTW-1:0] op_count;

    div_req_frontend #(.W(W), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .dv_x(dv_x), .dv_y(dv_y), .dv_go(dv_go), .dv_error(dv_error), .dv_rst(dv_rst),
        .dv_done(dv_done), .dv_q(dv_q), .dv_r(dv_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r),
        .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    typedef struct {
        logic [W-1:0] x, y;
        bit           hang;
        int           lat;
        int           acc;
        logic [W-1:0] eq, er;
        logic [1:0]   ee;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    hold = 0;
    int    spur_cnt = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Divider stub: returns x/y, x%y lat cycles after go unless the transaction hangs.
    initial begin
        int           cnt;
        int           spur_seen;
        bit           pend;
        logic [W-1:0] sq, sr;
        cnt = 0; spur_seen = 0; pend = 0; sq = '0; sr = '0;
        dv_done = 0; dv_q = '0; dv_r = '0;
        forever begin
            @(posedge clk);
            #2;
            dv_done = 0;
            dv_q = W'($urandom);
            dv_r = W'($urandom);
            if (rst) begin
                pend = 0;
            end else begin
                if (spur_cnt != spur_seen) begin
                    spur_seen = spur_cnt;
                    dv_done = 1;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 0;
                        dv_done = 1;
                        dv_q = sq;
                        dv_r = sr;
                    end
                end
                if (dv_go && sb.size() != 0 && !sb[0].hang) begin
                    pend = 1;
                    cnt = sb[0].lat;
                    sq = (dv_y != 0) ? dv_x / dv_y : '0;
                    sr = (dv_y != 0) ? dv_x % dv_y : '0;
                end
            end
        end
    end

    // Consumer: accepts once the response has been valid for more than hold cycles.
    initial begin
        int vcnt;
        vcnt = 0;
        rsp_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_valid) vcnt++;
            else vcnt = 0;
            rsp_ready = (vcnt > hold);
        end
    end

    // Monitor: pops the scoreboard on each response handshake.
    initial begin
        int         gos, go_cyc, done_cyc, rst_cyc, exp_lat;
        bit         prev_valid;
        logic [7:0] exp_ops;
        item_t      it;
        gos = 0; go_cyc = -1000; done_cyc = -1000; rst_cyc = -1000; prev_valid = 0; exp_ops = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ops = '0; gos = 0; prev_valid = 0;
            end else begin
                check_eq("op_count", op_count, exp_ops);
                if (dv_go) begin
                    check_eq("go_has_txn", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        check_eq("go_lat", cyc, sb[0].acc + 2);
                        check_eq("go_operands", {dv_x, dv_y}, {sb[0].x, sb[0].y});
                    end
                    check_eq("dv_error_at_go", dv_error, 0);
                    gos++;
                    go_cyc = cyc; done_cyc = -1000; rst_cyc = -1000;
                end
                if (dv_done && busy && !rsp_valid && gos > 0 && sb.size() != 0) begin
                    done_cyc = cyc;
                    check_eq("dv_ops_stable", {dv_x, dv_y}, {sb[0].x, sb[0].y});
                end
                if (dv_rst) begin
                    check_eq("dv_rst_lat", cyc, go_cyc + TIMEOUT);
                    check_eq("dv_rst_expected", sb.size() != 0 && sb[0].hang, 1);
                    rst_cyc = cyc;
                end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        it = sb[0];
                        if (!prev_valid) begin
                            exp_lat = (it.ee == 2'b01) ? it.acc + 1 :
                                      (it.ee == 2'b00) ? done_cyc + 1 : rst_cyc + 1;
                            check_eq("rsp_lat", cyc, exp_lat);
                            check_eq("go_count", gos, (it.ee == 2'b01) ? 0 : 1);
                        end
                        check_eq("rsp_q_r_err", {rsp_q, rsp_r, rsp_err}, {it.eq, it.er, it.ee});
                        check_eq("req_ready_in_resp", req_ready, 0);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            exp_ops++;
                            gos = 0;
                            prev_valid = 0;
                        end else begin
                            prev_valid = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit hang, input int lat);
        item_t it;
        bit    got;
        got = 0;
        it.x = x; it.y = y; it.hang = hang; it.lat = lat; it.acc = 0;
        if (y == 0) begin
            it.eq = '0; it.er = x; it.ee = 2'b01;
        end else if (hang) begin
            it.eq = '0; it.er = '0; it.ee = 2'b10;
        end else begin
            it.eq = x / y; it.er = x % y; it.ee = 2'b00;
        end
        @(negedge clk);
        req_valid = 1; req_x = x; req_y = y;
        for (int i = 0; i < 3000; i++) begin
            if (req_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check_eq("req_accept_timeout", req_ready, 1);
            req_valid = 0;
        end else begin
            it.acc = cyc;
            sb.push_back(it);
            @(posedge clk);
            #1;
            req_valid = 0;
            req_x = W'($urandom);
            req_y = W'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                idle = 1;
                break;
            end
        end
        if (!idle) check_eq("idle_timeout", busy, 0);
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        rst = 1; req_valid = 0; req_x = '0; req_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", {req_ready, rsp_valid, busy, dv_go, dv_rst, dv_error}, 6'b100000);
        check_eq("reset_data", {dv_x, dv_y, rsp_q, rsp_r, rsp_err, op_count}, '0);
        @(posedge clk);
        #1 rst = 0;

        send(4'd13, 4'd3, 0, 5);
        wait_idle();
        check_eq("op_count_first", op_count, 1);
        send(4'd9, 4'd0, 0, 1);
        wait_idle();
        send(4'd3, 4'd2, 1, 0);
        send(4'd15, 4'd5, 0, 3);
        wait_idle();
        send(4'd11, 4'd4, 0, TIMEOUT);
        wait_idle();
        hold = 10;
        send(4'd7, 4'd2, 0, 2);
        send(4'd5, 4'd1, 0, 1);
        wait_idle();

        repeat (60) begin
            hold = $urandom_range(0, 3);
            rx = W'($urandom);
            ry = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            send(rx, ry, ($urandom_range(0, 15) == 0), $urandom_range(1, 12));
        end
        wait_idle();
        hold = 0;

        spur_cnt++;
        repeat (4) begin
            @(negedge clk);
            check_eq("spur_done_ignored", {rsp_valid, busy}, 2'b00);
        end

        send(4'd14, 4'd3, 0, 40);
        repeat (8) @(negedge clk);
        check_eq("busy_in_wait", {busy, rsp_valid}, 2'b10);
        @(posedge clk);
        #1 rst = 1;
        sb.delete();
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_eq("post_reset", {rsp_valid, req_ready, busy, op_count}, {3'b010, 8'd0});
        repeat (50) begin
            @(negedge clk);
            check_eq("post_reset_no_rsp", rsp_valid, 0);
        end

        repeat (257) send(4'd15, 4'd1, 0, 1);
        wait_idle();
        check_eq("op_count_wrap", op_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
